// File: rtl/ppi_pkg.sv
// ppi_pkg: shared state encoding and control-word field positions for the PPI port A handshake.
package ppi_pkg;
  typedef enum logic [2:0] {UNCFG, IN_EMPTY, IN_FULL, OUT_EMPTY, OUT_FULL} state_t;
  localparam int MODESET_BIT = 7;
  localparam int DIR_BIT = 4;
  localparam logic [2:0] INTE_A_IN_IDX = 3'd4;
  localparam logic [2:0] INTE_A_OUT_IDX = 3'd6;
  localparam int DEFAULT_DATA_W = 8;
endpackage

// File: rtl/ppi_sync_edge.sv
// ppi_sync_edge: synchronizes an async active-low strobe and emits 1-cycle fall/rise pulses.
module ppi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic fall,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      prev <= sync[STAGES-1];
    end
  assign fall = prev & ~sync[STAGES-1];
  assign rise = ~prev & sync[STAGES-1];
endmodule

// File: rtl/ppi_mode1_handshake_ctrl.sv
// ppi_mode1_handshake_ctrl: PPI port A mode-1 strobed handshake controller.
// Define PPI_OVERRUN_DET_EN to enable sticky overrun detection; otherwise Overrun is tied low.
module ppi_mode1_handshake_ctrl import ppi_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CtrlWrite,
  input  logic [7:0]        CtrlWord,
  input  logic              CpuRd,
  input  logic              CpuWr,
  input  logic [DATA_W-1:0] CpuDataIn,
  output logic [DATA_W-1:0] CpuDataOut,
  input  logic [DATA_W-1:0] PortIn,
  output logic [DATA_W-1:0] PortOut,
  input  logic              STB_n,
  input  logic              ACK_n,
  output logic              IBF,
  output logic              OBF_n,
  output logic              INTR,
  output logic              Overrun,
  output logic              ControlEnable,
  output logic              GroupControl
);
  state_t state, nxt;
  logic stb_fall, stb_rise, ack_fall, ack_rise;
  logic inte_in, inte_out, in_mode, out_mode, mode_set, bsr, sel_in, sel_out, intr_clr, intr_set;
  logic [DATA_W-1:0] in_latch;
  logic unused_ok;
  ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_stb (.clk(clk), .reset(reset), .pin(STB_n), .fall(stb_fall), .rise(stb_rise));
  ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_ack (.clk(clk), .reset(reset), .pin(ACK_n), .fall(ack_fall), .rise(ack_rise));
  assign unused_ok = &{1'b0, CtrlWord[6:5]};
  assign in_mode = (state == IN_EMPTY) | (state == IN_FULL);
  assign out_mode = (state == OUT_EMPTY) | (state == OUT_FULL);
  assign mode_set = CtrlWrite & CtrlWord[MODESET_BIT];
  assign bsr = CtrlWrite & ~CtrlWord[MODESET_BIT] & (state != UNCFG);
  assign sel_in = bsr & (CtrlWord[3:1] == INTE_A_IN_IDX);
  assign sel_out = bsr & (CtrlWord[3:1] == INTE_A_OUT_IDX);
  // A CPU access or clearing an enable always beats a concurrent set condition
  assign intr_clr = (in_mode & CpuRd) | (out_mode & CpuWr) | ((sel_in | sel_out) & ~CtrlWord[0]);
  assign intr_set = ((state == IN_FULL) & stb_rise & inte_in) | ((state == OUT_EMPTY) & ack_rise & inte_out);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= UNCFG;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (mode_set) nxt = CtrlWord[DIR_BIT] ? IN_EMPTY : OUT_EMPTY;
    else if (in_mode) nxt = stb_fall ? IN_FULL : CpuRd ? IN_EMPTY : state;
    else if (out_mode) nxt = CpuWr ? OUT_FULL : ack_fall ? OUT_EMPTY : state;
  end
  always_comb begin
    ControlEnable = state != UNCFG;
    GroupControl = out_mode;
    IBF = state == IN_FULL;
    OBF_n = state != OUT_FULL;
    CpuDataOut = out_mode ? PortOut : in_latch;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      inte_in <= 1'b0;
      inte_out <= 1'b0;
      INTR <= 1'b0;
      in_latch <= '0;
      PortOut <= '0;
    end else if (mode_set) begin
      inte_in <= 1'b0;
      inte_out <= 1'b0;
      INTR <= 1'b0;
      in_latch <= '0;
      PortOut <= '0;
    end else begin
      if (sel_in) inte_in <= CtrlWord[0];
      if (sel_out) inte_out <= CtrlWord[0];
      if (in_mode && stb_fall) in_latch <= PortIn;
      if (out_mode && CpuWr) PortOut <= CpuDataIn;
      INTR <= ~intr_clr & (INTR | intr_set);
    end
`ifdef PPI_OVERRUN_DET_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) Overrun <= 1'b0;
    else if (mode_set) Overrun <= 1'b0;
    else if ((IBF & stb_fall) | ((state == OUT_FULL) & CpuWr)) Overrun <= 1'b1;
`else
  assign Overrun = 1'b0;
`endif
endmodule

// File: tb/tb_ppi_mode1_handshake_ctrl.sv
// tb_ppi_mode1_handshake_ctrl: directed and random handshakes against a transaction-level port model.
module tb_ppi_mode1_handshake_ctrl;
  localparam int SS = 2;
`ifdef PPI_OVERRUN_DET_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, CtrlWrite = 1'b0, CpuRd = 1'b0, CpuWr = 1'b0, STB_n = 1'b1, ACK_n = 1'b1;
  logic [7:0] CtrlWord = '0, CpuDataIn = '0, PortIn = '0;
  logic [7:0] CpuDataOut, PortOut;
  logic IBF, OBF_n, INTR, Overrun, ControlEnable, GroupControl;
  ppi_mode1_handshake_ctrl #(.DATA_W(8), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .CtrlWrite(CtrlWrite), .CtrlWord(CtrlWord), .CpuRd(CpuRd), .CpuWr(CpuWr),
    .CpuDataIn(CpuDataIn), .CpuDataOut(CpuDataOut), .PortIn(PortIn), .PortOut(PortOut), .STB_n(STB_n),
    .ACK_n(ACK_n), .IBF(IBF), .OBF_n(OBF_n), .INTR(INTR), .Overrun(Overrun), .ControlEnable(ControlEnable),
    .GroupControl(GroupControl));
  always #5 clk = ~clk;
  typedef struct packed {
    logic ibf, obf_n, intr, ovr, ce, gc;
    logic [7:0] dout, pout;
  } snap_t;
  snap_t exq[$];
  string nq[$];
  snap_t e_s, a_s;
  string n_s;
  logic chk_req = 1'b0;
  int checks = 0, failures = 0;
  int m_mode;
  bit m_full, m_intr, m_ovr, m_ie_in, m_ie_out;
  logic [7:0] m_din, m_pout;
  logic [2:0] oth [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
  function automatic snap_t expect_snap();
    snap_t s;
    s.ibf = (m_mode == 1) && m_full;
    s.obf_n = !((m_mode == 2) && m_full);
    s.intr = m_intr;
    s.ovr = m_ovr;
    s.ce = m_mode != 0;
    s.gc = m_mode == 2;
    s.dout = (m_mode == 2) ? m_pout : m_din;
    s.pout = m_pout;
    return s;
  endfunction
  function automatic void m_reset();
    m_mode = 0; m_full = 0; m_intr = 0; m_ovr = 0; m_ie_in = 0; m_ie_out = 0; m_din = '0; m_pout = '0;
  endfunction
  function automatic void m_ctrl(logic [7:0] w);
    if (w[7]) begin
      m_reset();
      m_mode = w[4] ? 1 : 2;
    end else if (m_mode != 0) begin
      if (w[3:1] == 3'd4) begin m_ie_in = w[0]; if (!w[0]) m_intr = 0; end
      if (w[3:1] == 3'd6) begin m_ie_out = w[0]; if (!w[0]) m_intr = 0; end
    end
  endfunction
  function automatic void m_fall_in(logic [7:0] d);
    if (m_mode == 1) begin
      if (m_full && OVR_EN) m_ovr = 1;
      m_din = d;
      m_full = 1;
    end
  endfunction
  function automatic void m_rise_in();
    if (m_mode == 1 && m_full && m_ie_in) m_intr = 1;
  endfunction
  function automatic void m_rd();
    if (m_mode == 1) begin m_full = 0; m_intr = 0; end
  endfunction
  function automatic void m_wr(logic [7:0] d);
    if (m_mode == 2) begin
      if (m_full && OVR_EN) m_ovr = 1;
      m_pout = d;
      m_full = 1;
      m_intr = 0;
    end
  endfunction
  function automatic void m_fall_ack();
    if (m_mode == 2) m_full = 0;
  endfunction
  function automatic void m_rise_ack();
    if (m_mode == 2 && !m_full && m_ie_out) m_intr = 1;
  endfunction
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(string n);
    exq.push_back(expect_snap());
    nq.push_back(n);
    chk_req = 1'b1;
    tick(1);
    chk_req = 1'b0;
  endtask
  task automatic ctrl(logic [7:0] w);
    CtrlWord = w; CtrlWrite = 1'b1; tick(1); CtrlWrite = 1'b0; m_ctrl(w);
  endtask
  task automatic rd();
    CpuRd = 1'b1; tick(1); CpuRd = 1'b0; m_rd();
  endtask
  task automatic wr(logic [7:0] d);
    CpuDataIn = d; CpuWr = 1'b1; tick(1); CpuWr = 1'b0; m_wr(d);
  endtask
  task automatic strobe(logic [7:0] d, int low);
    PortIn = d; STB_n = 1'b0; tick(low); m_fall_in(d);
    STB_n = 1'b1; tick(SS + 2); m_rise_in();
    PortIn = 8'($urandom);
  endtask
  task automatic ack(int low);
    ACK_n = 1'b0; tick(low); m_fall_ack();
    ACK_n = 1'b1; tick(SS + 2); m_rise_ack();
  endtask
  // Monitor: compares DUT outputs with the queued expectation on each requested sample
  always @(negedge clk)
    if (chk_req) begin
      a_s = {IBF, OBF_n, INTR, Overrun, ControlEnable, GroupControl, CpuDataOut, PortOut};
      if (exq.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow: no expectation queued");
      end else begin
        e_s = exq.pop_front();
        n_s = nq.pop_front();
        checks++;
        if (a_s !== e_s) begin
          failures++;
          $display("FAIL %s: got ibf=%b obf_n=%b intr=%b ovr=%b ce=%b gc=%b dout=%h pout=%h, expected ibf=%b obf_n=%b intr=%b ovr=%b ce=%b gc=%b dout=%h pout=%h",
            n_s, a_s.ibf, a_s.obf_n, a_s.intr, a_s.ovr, a_s.ce, a_s.gc, a_s.dout, a_s.pout,
            e_s.ibf, e_s.obf_n, e_s.intr, e_s.ovr, e_s.ce, e_s.gc, e_s.dout, e_s.pout);
        end
      end
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [2:0] idx;
    m_reset();
    tick(2);
    check("reset");
    reset = 1'b0;
    tick(1);
    ctrl(8'h90);
    ctrl(8'h09);
    check("t1_cfg");
    PortIn = 8'hA5; STB_n = 1'b0;
    tick(2);
    check("t1_ibf_before_3rd_edge");
    m_fall_in(8'hA5);
    check("t1_ibf_at_3rd_edge");
    tick(2);
    STB_n = 1'b1;
    tick(SS + 2); m_rise_in();
    check("t1_intr");
    rd();
    check("t1_read");
    ctrl(8'h08);
    strobe(8'h5A, 5);
    check("t6_inte_off");
    strobe(8'hC3, 4);
    check("t3_overwrite");
    ctrl(8'h09);
    strobe(8'h11, 4);
    check("t4_pre");
    PortIn = 8'h77; STB_n = 1'b0;
    tick(2);
    CpuRd = 1'b1; tick(1); CpuRd = 1'b0;
    m_fall_in(8'h77); m_intr = 0;
    check("t4_stb_rd_same_cycle");
    STB_n = 1'b1; tick(SS + 2); m_rise_in();
    check("t4_rise");
    ctrl(8'h80);
    ctrl(8'h0D);
    wr(8'h3C);
    check("t2_write");
    ACK_n = 1'b0; tick(SS + 1); m_fall_ack();
    check("t2_ack_fall");
    ACK_n = 1'b1; tick(SS + 2); m_rise_ack();
    check("t2_intr");
    wr(8'h44);
    ACK_n = 1'b0; tick(2);
    CpuDataIn = 8'h99; CpuWr = 1'b1; tick(1); CpuWr = 1'b0;
    m_wr(8'h99);
    check("wr_ack_same_cycle");
    ACK_n = 1'b1; tick(SS + 2); m_rise_ack();
    check("wr_ack_release");
    ACK_n = 1'b0; tick(1);
    #2 reset = 1'b1;
    m_reset();
    check("t5_async_reset");
    tick(2);
    reset = 1'b0;
    tick(3);
    ACK_n = 1'b1; tick(SS + 2);
    check("t5_no_intr_after_reset");
    ctrl({1'b1, 2'($urandom), 1'($urandom), 4'($urandom)});
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 6))
        0: if ($urandom_range(0, 3) == 0) ctrl({1'b1, 2'($urandom), 1'($urandom), 4'($urandom)});
        1: begin
          idx = ($urandom_range(0, 2) == 0) ? oth[$urandom_range(0, 5)] : ((m_mode == 1) ? 3'd4 : 3'd6);
          ctrl({1'b0, 3'($urandom), idx, 1'($urandom)});
        end
        2: rd();
        3: wr(8'($urandom));
        4, 5: strobe(8'($urandom), $urandom_range(4, 7));
        default: ack($urandom_range(3, 6));
      endcase
      check($sformatf("rand_%0d", i));
    end
    tick(2);
    if (exq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d expectations unchecked, required 0", exq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
